// File: rtl/game_controller.sv
// game_controller
// Round sequencer sitting directly upstream of the seven-segment display stage.
// A round runs as follows:
//   1. Latch a BCD target from the random source.
//   2. Show the target for SHOW_TICKS tick pulses.
//   3. Collect four BCD digits from the switches, committed with the enter button.
//   4. Present the compare result and keep a saturating win streak.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   tick         one-clk timing pulse from the clock divider
//   btnStart     one-clk debounced start pulse
//   btnEnter     one-clk debounced digit-commit pulse
//   sw[3:0]      BCD digit on the switches
//   randIn[15:0] free-running random BCD value
//   randInt[15:0]    latched target, to the display
//   displayPhase     high while the target is shown
//   userInput[15:0]  digits entered so far, newest digit in [3:0]
//   inputReady       high in RESULT
//   correct          registered compare result, valid while inputReady is high
//   streak[3:0]      consecutive correct rounds, saturating at 15
//
// Optional build macro ENTRY_TIMEOUT_EN:
//   Adds the parameter ENTRY_TICKS and an idle timeout during digit entry.
//   When the timeout expires, the round ends as a loss and the partial entry
//   is kept on userInput.
//
// State table:
//   IDLE   | waiting for the first start pulse after reset
//   SHOW   | target on display, counting tick pulses
//   ENTRY  | collecting user digits
//   RESULT | result valid, waiting for start of the next round

module game_controller #(
    parameter int SHOW_TICKS = 4,
    parameter int NUM_DIGITS = 4
`ifdef ENTRY_TIMEOUT_EN
    ,
    parameter int ENTRY_TICKS = 10
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        btnStart,
    input  logic        btnEnter,
    input  logic [3:0]  sw,
    input  logic [15:0] randIn,
    output logic [15:0] randInt,
    output logic        displayPhase,
    output logic [15:0] userInput,
    output logic        inputReady,
    output logic        correct,
    output logic [3:0]  streak
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW   = 2'd1,
        ENTRY  = 2'd2,
        RESULT = 2'd3
    } state_t;

    localparam logic [3:0] SHOW_LAST  = 4'(SHOW_TICKS - 1);
    localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

    state_t      state;
    logic [3:0]  tickCnt;
    logic [2:0]  digitCnt;
    logic        digitOk;
    logic [15:0] nextEntry;
    logic        nextMatch;

`ifdef ENTRY_TIMEOUT_EN
    localparam logic [7:0] ENTRY_LAST = 8'(ENTRY_TICKS - 1);
    logic [7:0]  entryCnt;
`endif

    // Non-BCD switch values are rejected outright.
    assign digitOk   = btnEnter && (sw <= 4'd9);
    assign nextEntry = {userInput[11:0], sw};
    assign nextMatch = (nextEntry == randInt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            randInt      <= '0;
            userInput    <= '0;
            displayPhase <= 1'b0;
            inputReady   <= 1'b0;
            correct      <= 1'b0;
            streak       <= '0;
            tickCnt      <= '0;
            digitCnt     <= '0;
`ifdef ENTRY_TIMEOUT_EN
            entryCnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE, RESULT: begin
                    if (btnStart) begin
                        state        <= SHOW;
                        randInt      <= randIn;
                        userInput    <= '0;
                        tickCnt      <= '0;
                        displayPhase <= 1'b1;
                        inputReady   <= 1'b0;
                        correct      <= 1'b0;
                    end
                end

                SHOW: begin
                    if (tick) begin
                        if (tickCnt == SHOW_LAST) begin
                            state        <= ENTRY;
                            displayPhase <= 1'b0;
                            digitCnt     <= '0;
`ifdef ENTRY_TIMEOUT_EN
                            entryCnt     <= '0;
`endif
                        end
                        tickCnt <= tickCnt + 4'd1;
                    end
                end

                ENTRY: begin
                    if (digitOk) begin
                        userInput <= nextEntry;
                        digitCnt  <= digitCnt + 3'd1;
`ifdef ENTRY_TIMEOUT_EN
                        entryCnt  <= '0;
`endif
                        // Last digit: result and streak settle on the same edge.
                        if (digitCnt == LAST_DIGIT) begin
                            state      <= RESULT;
                            inputReady <= 1'b1;
                            correct    <= nextMatch;
                            if (!nextMatch)
                                streak <= '0;
                            else if (streak != 4'd15)
                                streak <= streak + 4'd1;
                        end
                    end
`ifdef ENTRY_TIMEOUT_EN
                    // A digit on the same edge takes priority over the timeout.
                    else if (tick) begin
                        if (entryCnt == ENTRY_LAST) begin
                            state      <= RESULT;
                            inputReady <= 1'b1;
                            correct    <= 1'b0;
                            streak     <= '0;
                        end
                        entryCnt <= entryCnt + 8'd1;
                    end
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller
// Directed bench for game_controller with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled on the following
// falling edge, i.e. half a period after the rising edge that consumed them.
// Build with +define+ENTRY_TIMEOUT_EN to exercise the entry timeout.

module tb_game_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        btnStart = 1'b0;
    logic        btnEnter = 1'b0;
    logic [3:0]  sw = 4'd0;
    logic [15:0] randIn = 16'h0000;
    logic [15:0] randInt;
    logic        displayPhase;
    logic [15:0] userInput;
    logic        inputReady;
    logic        correct;
    logic [3:0]  streak;

    int checks = 0;
    int errors = 0;

    game_controller dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .btnStart     (btnStart),
        .btnEnter     (btnEnter),
        .sw           (sw),
        .randIn       (randIn),
        .randInt      (randInt),
        .displayPhase (displayPhase),
        .userInput    (userInput),
        .inputReady   (inputReady),
        .correct      (correct),
        .streak       (streak)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One-cycle pulse on the selected inputs; returns on the falling edge
    // after the rising edge that consumed it.
    task automatic pulseIn(input logic s, input logic e, input logic t, input logic [3:0] d);
        @(negedge clk);
        btnStart = s;
        btnEnter = e;
        tick     = t;
        sw       = d;
        @(negedge clk);
        btnStart = 1'b0;
        btnEnter = 1'b0;
        tick     = 1'b0;
    endtask

    task automatic startAndShow(input logic [15:0] target);
        randIn = target;
        pulseIn(1'b1, 1'b0, 1'b0, 4'd0);
        checkVal("startTarget", 32'(randInt), 32'(target));
        checkVal("startPhase", 32'(displayPhase), 32'd1);
        checkVal("startReadyLow", 32'(inputReady), 32'd0);
        for (int i = 0; i < 4; i++) pulseIn(1'b0, 1'b0, 1'b1, 4'd0);
        checkVal("showDone", 32'(displayPhase), 32'd0);
    endtask

    task automatic enterDigits(input logic [15:0] entry);
        for (int i = 3; i >= 0; i--) pulseIn(1'b0, 1'b1, 1'b0, entry[i*4 +: 4]);
    endtask

    logic [15:0] tgt;
    logic [3:0]  expStreak;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        checkVal("rstRandInt", 32'(randInt), 32'd0);
        checkVal("rstUser", 32'(userInput), 32'd0);
        checkVal("rstPhase", 32'(displayPhase), 32'd0);
        checkVal("rstReady", 32'(inputReady), 32'd0);
        checkVal("rstCorrect", 32'(correct), 32'd0);
        checkVal("rstStreak", 32'(streak), 32'd0);
        rst = 1'b0;

        // Tick in IDLE does nothing.
        pulseIn(1'b0, 1'b0, 1'b1, 4'd0);
        checkVal("idleTick", 32'(displayPhase), 32'd0);

        // Round 1: target 1234 with exact show timing and
        // start/enter ignored during SHOW.
        randIn = 16'h1234;
        pulseIn(1'b1, 1'b0, 1'b0, 4'd0);
        checkVal("r1Target", 32'(randInt), 32'h1234);
        checkVal("r1Phase", 32'(displayPhase), 32'd1);
        randIn = 16'h9999;
        pulseIn(1'b1, 1'b0, 1'b0, 4'd0);
        pulseIn(1'b0, 1'b1, 1'b0, 4'd5);
        checkVal("showIgnTarget", 32'(randInt), 32'h1234);
        checkVal("showIgnUser", 32'(userInput), 32'd0);
        for (int i = 0; i < 3; i++) begin
            pulseIn(1'b0, 1'b0, 1'b1, 4'd0);
            checkVal("r1PhaseHeld", 32'(displayPhase), 32'd1);
        end
        pulseIn(1'b0, 1'b0, 1'b1, 4'd0);
        checkVal("r1PhaseEnd", 32'(displayPhase), 32'd0);

        pulseIn(1'b0, 1'b1, 1'b0, 4'd1);
        checkVal("r1d1", 32'(userInput), 32'h0001);
        pulseIn(1'b0, 1'b1, 1'b0, 4'd2);
        checkVal("r1d2", 32'(userInput), 32'h0012);
`ifndef ENTRY_TIMEOUT_EN
        // Without the timeout, ticks in ENTRY change nothing.
        for (int i = 0; i < 12; i++) pulseIn(1'b0, 1'b0, 1'b1, 4'd0);
        checkVal("entryTickIgn", 32'(inputReady), 32'd0);
`endif
        // Start and enter together in ENTRY: the digit is taken.
        pulseIn(1'b1, 1'b1, 1'b0, 4'd3);
        checkVal("r1d3", 32'(userInput), 32'h0123);
        checkVal("r1ReadyLow", 32'(inputReady), 32'd0);
        pulseIn(1'b0, 1'b1, 1'b0, 4'd4);
        checkVal("r1d4", 32'(userInput), 32'h1234);
        checkVal("r1Ready", 32'(inputReady), 32'd1);
        checkVal("r1Correct", 32'(correct), 32'd1);
        checkVal("r1Streak", 32'(streak), 32'd1);

        // Round 2: target 5678, wrong entry, invalid digit rejected.
        // Start and enter together in RESULT: start acts.
        randIn = 16'h5678;
        pulseIn(1'b1, 1'b1, 1'b0, 4'd7);
        checkVal("r2Target", 32'(randInt), 32'h5678);
        checkVal("r2UserClr", 32'(userInput), 32'd0);
        checkVal("r2ReadyClr", 32'(inputReady), 32'd0);
        checkVal("r2CorrectClr", 32'(correct), 32'd0);
        for (int i = 0; i < 4; i++) pulseIn(1'b0, 1'b0, 1'b1, 4'd0);
        pulseIn(1'b0, 1'b1, 1'b0, 4'd5);
        pulseIn(1'b0, 1'b1, 1'b0, 4'd6);
        pulseIn(1'b0, 1'b1, 1'b0, 4'hA);
        checkVal("r2BadDigit", 32'(userInput), 32'h0056);
        pulseIn(1'b0, 1'b1, 1'b0, 4'd7);
        checkVal("r2NotDone", 32'(inputReady), 32'd0);
        pulseIn(1'b0, 1'b1, 1'b0, 4'd9);
        checkVal("r2User", 32'(userInput), 32'h5679);
        checkVal("r2Ready", 32'(inputReady), 32'd1);
        checkVal("r2Correct", 32'(correct), 32'd0);
        checkVal("r2Streak", 32'(streak), 32'd0);

        // Sixteen wins in a row: the streak saturates at 15.
        expStreak = 4'd0;
        for (int r = 0; r < 16; r++) begin
            tgt = {4'(r % 10), 4'((r + 3) % 10), 4'((r + 7) % 10), 4'((r + 1) % 10)};
            startAndShow(tgt);
            enterDigits(tgt);
            if (expStreak != 4'd15) expStreak = expStreak + 4'd1;
            checkVal("winCorrect", 32'(correct), 32'd1);
            checkVal("winStreak", 32'(streak), 32'(expStreak));
        end
        checkVal("streakSat", 32'(streak), 32'd15);

        // Wrong round after saturation clears the streak.
        startAndShow(16'h2468);
        enterDigits(16'h2469);
        checkVal("lossCorrect", 32'(correct), 32'd0);
        checkVal("lossStreak", 32'(streak), 32'd0);

`ifdef ENTRY_TIMEOUT_EN
        // Two digits, then ten idle ticks: timeout with partial entry.
        startAndShow(16'h4321);
        pulseIn(1'b0, 1'b1, 1'b0, 4'd4);
        pulseIn(1'b0, 1'b1, 1'b0, 4'd3);
        for (int i = 0; i < 9; i++) pulseIn(1'b0, 1'b0, 1'b1, 4'd0);
        checkVal("toNotYet", 32'(inputReady), 32'd0);
        pulseIn(1'b0, 1'b0, 1'b1, 4'd0);
        checkVal("toReady", 32'(inputReady), 32'd1);
        checkVal("toCorrect", 32'(correct), 32'd0);
        checkVal("toUser", 32'(userInput), 32'h0043);
        checkVal("toStreak", 32'(streak), 32'd0);
`endif

        // Reset during ENTRY clears everything without a clock edge.
        startAndShow(16'h0099);
        pulseIn(1'b0, 1'b1, 1'b0, 4'd1);
        pulseIn(1'b0, 1'b1, 1'b0, 4'd2);
        checkVal("preRstUser", 32'(userInput), 32'h0012);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checkVal("asyncUser", 32'(userInput), 32'd0);
        checkVal("asyncTarget", 32'(randInt), 32'd0);
        checkVal("asyncPhase", 32'(displayPhase), 32'd0);
        checkVal("asyncReady", 32'(inputReady), 32'd0);
        checkVal("asyncCorrect", 32'(correct), 32'd0);
        checkVal("asyncStreak", 32'(streak), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_controller.md
Name: game_controller

Overview:
- Sequencing FSM directly upstream of the seven-segment display stage.
- Latches a 16-bit BCD target from the random source and drives displayPhase while the target is shown.
- Collects four user BCD digits from switches plus an enter pulse and publishes them on userInput.
- Raises inputReady and correct for the result screen, and keeps a win-streak count.

Parameters:
- SHOW_TICKS, 4: number of tick pulses for which the target stays on display (legal range 1..15).
- NUM_DIGITS, 4: digits collected per round. Fixed at 4 to match the 16-bit display bus.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous active-high reset.
- tick  in  1  one-clk-wide timing pulse (nominally 1 Hz) from the clock divider.
- btnStart  in  1  one-clk-wide debounced start pulse.
- btnEnter  in  1  one-clk-wide debounced digit-commit pulse.
- sw  in  4  BCD digit currently on the switches.
- randIn  in  16  free-running random BCD value; sampled on start.
- randInt  out  16  latched target value, to the display.
- displayPhase  out  1  high while the target is shown.
- userInput  out  16  digits entered so far; newest digit in [3:0].
- inputReady  out  1  high in RESULT.
- correct  out  1  registered compare result; valid while inputReady is high.
- streak  out  4  consecutive correct rounds, saturating at 15.

Behaviour:
- Reset (async, any state): FSM to IDLE; randInt=0, userInput=0, displayPhase=0, inputReady=0, correct=0, streak=0, tick counter=0, digit counter=0.
- States: IDLE, SHOW, ENTRY, RESULT. All outputs are registered.
- IDLE:
  - btnStart -> SHOW on the next edge.
  - Same edge: randInt<=randIn, userInput<=0, tickCnt<=0, displayPhase<=1.
- SHOW:
  - Each tick increments tickCnt.
  - On the tick that makes tickCnt==SHOW_TICKS -> ENTRY, displayPhase<=0, digitCnt<=0.
  - btnEnter and btnStart are ignored.
- ENTRY:
  - btnEnter with sw<=9: userInput<={userInput[11:0],sw}, digitCnt+1.
  - btnEnter with sw>9: ignored; no shift, no count.
  - When the accepted digit is the 4th (digitCnt 3->4): go to RESULT on the same edge. inputReady<=1 and correct<=({userInput[11:0],sw}==randInt), so correct is valid on the first RESULT cycle.
  - btnStart in ENTRY is ignored.
- RESULT:
  - On entry, update streak: correct -> streak+1 saturating at 15; incorrect -> streak<=0. Applied on the same edge as the inputReady rise.
  - btnStart -> SHOW: new round with fresh randIn latch, userInput<=0, inputReady<=0, correct<=0, displayPhase<=1.
- Simultaneous btnStart and btnEnter in the same cycle: only the pulse relevant to the current state acts; the other is dropped.
- A tick arriving outside SHOW has no effect; tickCnt holds.
- Reset asserted mid-round abandons the round; streak is lost.
- Latency:
  - Start pulse to displayPhase high: 1 clk.
  - 4th enter to inputReady high: 1 clk.

Optional Feature:
- Macro: ENTRY_TIMEOUT_EN.
- When defined:
  - Parameter ENTRY_TICKS (default 10) and a tick counter active in ENTRY, cleared on every accepted digit.
  - When it reaches ENTRY_TICKS: -> RESULT with inputReady<=1, correct<=0, streak<=0, and userInput holding the partial entry.
  - If the timeout and a 4th digit land on the same edge, the digit wins and is compared normally.
- When undefined: ENTRY waits indefinitely and no timeout counter is synthesised.

Test Plan:
- Reset then start with randIn=16'h1234 -> randInt=16'h1234, displayPhase=1 for exactly 4 ticks then 0, state ENTRY.
- Enter digits 1,2,3,4 -> userInput steps 0001,0012,0123,1234; inputReady=1 and correct=1 one clk after the 4th enter; streak=1.
- Target 16'h5678, enter 5,6,7,9 -> correct=0, streak returns to 0; enter with sw=4'hA mid-entry -> userInput unchanged.
- 16 consecutive wins -> streak saturates at 15; start during SHOW and enter during SHOW -> no state or output change.
- Assert rst during ENTRY with userInput=16'h0012 -> all outputs 0 immediately, without waiting for a clk edge.
- With ENTRY_TIMEOUT_EN: enter 2 digits then 10 ticks idle -> inputReady=1, correct=0, userInput=16'h00xy (the two entered digits).
